// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage core: datapath widths, ALU opcodes,
// the zero-register address and the EX control bundle.
// No logic; imported by id_ex_stage and fwd_mux.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  localparam logic [RADDR_W-1:0] REG_ZERO = '0;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_LUI = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_SLT = 4'd9;

  // Control bits that travel with an instruction through EX.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ex_ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM result, else MEM/WB data, else RF data.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, evaluated every cycle.
// Ports: addr/rf_data = registered source register and its RF value;
//        exmem_* / memwb_* = forward sources; data = selected operand.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int XLEN_P    = XLEN,
  parameter int RADDR_W_P = RADDR_W
) (
  input  logic [RADDR_W_P-1:0] addr,
  input  logic [XLEN_P-1:0]    rf_data,
  input  logic                 exmem_reg_write,
  input  logic [RADDR_W_P-1:0] exmem_rd,
  input  logic [XLEN_P-1:0]    exmem_result,
  input  logic                 memwb_reg_write,
  input  logic [RADDR_W_P-1:0] memwb_rd,
  input  logic [XLEN_P-1:0]    memwb_data,
  output logic [XLEN_P-1:0]    data
);

  logic exmem_hit;
  logic memwb_hit;

  // Register 0 is hardwired; a writer targeting it must never be forwarded.
  assign exmem_hit = exmem_reg_write && (exmem_rd != RADDR_W_P'(REG_ZERO)) && (exmem_rd == addr);
  assign memwb_hit = memwb_reg_write && (memwb_rd != RADDR_W_P'(REG_ZERO)) && (memwb_rd == addr);

  // The younger producer (EX/MEM) holds the most recent value, so it wins.
  always_comb begin
    data = rf_data;
    if (exmem_hit)
      data = exmem_result;
    else if (memwb_hit)
      data = memwb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX operand forwarding.
// Latency: ID fields captured at edge N drive EX outputs after edge N; forwarding is combinational.
// Backpressure: load-use hazard raises id_stall (unless flushed) and inserts one bubble into EX.
// Ports: id_* = decoded instruction; ex_flush = redirect squash; exmem_*/memwb_* = forward
//        sources; alu_* = ALU inputs; ex_* = control/data for EX/MEM; id_stall = hold IF/ID.
// Optional: define ID_EX_PERF_CNT_EN to add perf_stall_cnt / perf_flush_cnt outputs.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN_P    = XLEN,
  parameter int RADDR_W_P = RADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [XLEN_P-1:0]    id_pc,
  input  logic [RADDR_W_P-1:0] id_rs_addr,
  input  logic [RADDR_W_P-1:0] id_rt_addr,
  input  logic [RADDR_W_P-1:0] id_rd_addr,
  input  logic [XLEN_P-1:0]    id_rs_data,
  input  logic [XLEN_P-1:0]    id_rt_data,
  input  logic [XLEN_P-1:0]    id_imm,
  input  logic                 id_alu_src,
  input  logic [3:0]           id_alu_op,
  input  logic [4:0]           id_shamt,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic                 id_mem_write,
  input  logic                 id_mem_to_reg,
  input  logic                 ex_flush,
  input  logic                 exmem_reg_write,
  input  logic [RADDR_W_P-1:0] exmem_rd,
  input  logic [XLEN_P-1:0]    exmem_result,
  input  logic                 memwb_reg_write,
  input  logic [RADDR_W_P-1:0] memwb_rd,
  input  logic [XLEN_P-1:0]    memwb_data,
  output logic                 id_stall,
  output logic [XLEN_P-1:0]    alu_in1,
  output logic [XLEN_P-1:0]    alu_in2,
  output logic [3:0]           alu_op,
  output logic [4:0]           alu_shamt,
  output logic                 ex_valid,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_mem_to_reg,
  output logic [RADDR_W_P-1:0] ex_rd,
  output logic [XLEN_P-1:0]    ex_pc,
  output logic [XLEN_P-1:0]    ex_store_data
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);

  ex_ctrl_t               ex_ctrl;
  logic [RADDR_W_P-1:0]   ex_rs_addr;
  logic [RADDR_W_P-1:0]   ex_rt_addr;
  logic [XLEN_P-1:0]      ex_rs_data;
  logic [XLEN_P-1:0]      ex_rt_data;
  logic [XLEN_P-1:0]      ex_imm;
  logic                   ex_alu_src;
  logic                   hazard;
  logic [XLEN_P-1:0]      fwd_rs;
  logic [XLEN_P-1:0]      fwd_rt;

  // Conservative: any source-address match against an in-flight load stalls,
  // whether or not the instruction actually reads that operand.
  assign hazard = ex_valid && ex_ctrl.mem_read && (ex_rd != RADDR_W_P'(REG_ZERO)) &&
                  ((ex_rd == id_rs_addr) || (ex_rd == id_rt_addr)) && id_valid;

  // A redirect squashes the ID instruction anyway, so there is nothing to hold.
  assign id_stall = hazard && !ex_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_rd      <= '0;
      ex_pc      <= '0;
      ex_rs_addr <= '0;
      ex_rt_addr <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_alu_src <= 1'b0;
      alu_op     <= ALU_ADD;
      alu_shamt  <= '0;
    end else if (ex_flush || hazard) begin
      // Bubble: zero everything so the EX outputs are deterministic.
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_rd      <= '0;
      ex_pc      <= '0;
      ex_rs_addr <= '0;
      ex_rt_addr <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_alu_src <= 1'b0;
      alu_op     <= ALU_ADD;
      alu_shamt  <= '0;
    end else begin
      ex_valid   <= id_valid;
      ex_ctrl    <= id_valid ? ex_ctrl_t'({id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg})
                             : ex_ctrl_t'('0);
      ex_rd      <= id_rd_addr;
      ex_pc      <= id_pc;
      ex_rs_addr <= id_rs_addr;
      ex_rt_addr <= id_rt_addr;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_alu_src <= id_alu_src;
      alu_op     <= id_alu_op;
      alu_shamt  <= id_shamt;
    end
  end

  fwd_mux #(.XLEN_P(XLEN_P), .RADDR_W_P(RADDR_W_P)) u_fwd_rs (
    .addr            (ex_rs_addr),
    .rf_data         (ex_rs_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_data      (memwb_data),
    .data            (fwd_rs)
  );

  fwd_mux #(.XLEN_P(XLEN_P), .RADDR_W_P(RADDR_W_P)) u_fwd_rt (
    .addr            (ex_rt_addr),
    .rf_data         (ex_rt_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_data      (memwb_data),
    .data            (fwd_rt)
  );

  assign alu_in1       = fwd_rs;
  assign alu_in2       = ex_alu_src ? ex_imm : fwd_rt;
  // Stores always need the (forwarded) rt value, independent of alu_src.
  assign ex_store_data = fwd_rt;

  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;

`ifdef ID_EX_PERF_CNT_EN
  // Flush count only covers squashes of real instructions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (id_stall)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (ex_flush && id_valid)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: scoreboard of expected EX outputs plus
// directed checks for reset, forwarding priority, load-use, flush and stores.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic [4:0]  shamt;
    logic        rw, mr, mw, m2r;
  } instr_t;

  typedef struct packed {
    logic        ew;
    logic [4:0]  erd;
    logic [31:0] eres;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wdata;
  } fwd_t;

  typedef struct packed {
    logic [4:0]  ctrl;   // valid, rw, mr, mw, m2r
    logic [4:0]  rd;
    logic [31:0] pc, in1, in2;
    logic [3:0]  op;
    logic [4:0]  shamt;
    logic [31:0] sd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alu_src;
  logic [3:0]  id_alu_op;
  logic [4:0]  id_shamt;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        ex_flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic        id_stall;
  logic [31:0] alu_in1, alu_in2;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [4:0]  ex_rd;
  logic [31:0] ex_pc, ex_store_data;

  int checks = 0;
  int errors = 0;

  instr_t ms;          // bench model of the ID/EX register contents
  exp_t   sb_q[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_shamt(id_shamt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .ex_flush(ex_flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .id_stall(id_stall), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_op(alu_op), .alu_shamt(alu_shamt),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_store_data(ex_store_data)
  );

  function automatic logic [31:0] fwd_val(input logic [4:0] a, input logic [31:0] rf, input fwd_t f);
    if (f.ew && f.erd != 5'd0 && f.erd == a) return f.eres;
    if (f.ww && f.wrd != 5'd0 && f.wrd == a) return f.wdata;
    return rf;
  endfunction

  task automatic drive_id(input instr_t i, input logic flush);
    id_valid = i.valid; id_pc = i.pc;
    id_rs_addr = i.rs; id_rt_addr = i.rt; id_rd_addr = i.rd;
    id_rs_data = i.rs_data; id_rt_data = i.rt_data; id_imm = i.imm;
    id_alu_src = i.alu_src; id_alu_op = i.alu_op; id_shamt = i.shamt;
    id_reg_write = i.rw; id_mem_read = i.mr; id_mem_write = i.mw; id_mem_to_reg = i.m2r;
    ex_flush = flush;
  endtask

  task automatic drive_fwd(input fwd_t f);
    exmem_reg_write = f.ew; exmem_rd = f.erd; exmem_result = f.eres;
    memwb_reg_write = f.ww; memwb_rd = f.wrd; memwb_data = f.wdata;
  endtask

  // One pipeline cycle: drive ID at negedge, check id_stall, push expected EX
  // state, clock, apply forward sources, pop and compare.
  task automatic step(input instr_t i, input logic flush, input fwd_t f);
    logic haz, exp_stall;
    exp_t e, got;
    @(negedge clk);
    drive_id(i, flush);
    #1;
    haz = ms.valid && ms.mr && ms.rd != 5'd0 && (ms.rd == i.rs || ms.rd == i.rt) && i.valid;
    exp_stall = haz && !flush;
    checks++;
    if (id_stall !== exp_stall) begin
      errors++;
      $display("FAIL id_stall: got %b expected %b", id_stall, exp_stall);
    end
    if (flush || haz) ms = '0;
    else begin
      ms = i;
      if (!i.valid) begin ms.rw = 0; ms.mr = 0; ms.mw = 0; ms.m2r = 0; end
    end
    e.ctrl  = {ms.valid, ms.rw, ms.mr, ms.mw, ms.m2r};
    e.rd    = ms.rd;
    e.pc    = ms.pc;
    e.in1   = fwd_val(ms.rs, ms.rs_data, f);
    e.sd    = fwd_val(ms.rt, ms.rt_data, f);
    e.in2   = ms.alu_src ? ms.imm : e.sd;
    e.op    = ms.alu_op;
    e.shamt = ms.shamt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    drive_fwd(f);
    #1;
    got = sb_q.pop_front();
    checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== got.ctrl) begin
      errors++;
      $display("FAIL ex_ctrl: got %b expected %b",
               {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, got.ctrl);
    end
    checks++;
    if (ex_rd !== got.rd || ex_pc !== got.pc) begin
      errors++;
      $display("FAIL ex_rd_pc: got rd=%0d pc=%h expected rd=%0d pc=%h", ex_rd, ex_pc, got.rd, got.pc);
    end
    checks++;
    if (alu_in1 !== got.in1) begin
      errors++;
      $display("FAIL alu_in1: got %h expected %h", alu_in1, got.in1);
    end
    checks++;
    if (alu_in2 !== got.in2) begin
      errors++;
      $display("FAIL alu_in2: got %h expected %h", alu_in2, got.in2);
    end
    checks++;
    if (alu_op !== got.op || alu_shamt !== got.shamt) begin
      errors++;
      $display("FAIL alu_ctl: got op=%0d sh=%0d expected op=%0d sh=%0d", alu_op, alu_shamt, got.op, got.shamt);
    end
    checks++;
    if (ex_store_data !== got.sd) begin
      errors++;
      $display("FAIL store_data: got %h expected %h", ex_store_data, got.sd);
    end
  endtask

  function automatic instr_t alu_rr(input logic [4:0] rs, rt, rd, input logic [31:0] a, b);
    instr_t i = '0;
    i.valid = 1; i.pc = 32'h100; i.rs = rs; i.rt = rt; i.rd = rd;
    i.rs_data = a; i.rt_data = b; i.rw = 1;
    return i;
  endfunction

  function automatic instr_t load(input logic [4:0] rd);
    instr_t i = '0;
    i.valid = 1; i.pc = 32'h200; i.rs = 5'd9; i.rd = rd; i.alu_src = 1; i.imm = 32'h4;
    i.rw = 1; i.mr = 1; i.m2r = 1;
    return i;
  endfunction

  task automatic check_reset_state(input string tag);
    checks++;
    if (ex_valid !== 1'b0 || id_stall !== 1'b0 || ex_reg_write !== 1'b0 || alu_op !== 4'd0 ||
        ex_rd !== 5'd0 || alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || ex_store_data !== 32'd0) begin
      errors++;
      $display("FAIL %s: got v=%b st=%b rw=%b op=%0d rd=%0d in1=%h in2=%h sd=%h expected all zero",
               tag, ex_valid, id_stall, ex_reg_write, alu_op, ex_rd, alu_in1, alu_in2, ex_store_data);
    end
  endtask

  task automatic test_reset();
    fwd_t nf = '0;
    rst = 1;
    drive_id('0, 1'b0);
    drive_fwd(nf);
    repeat (3) @(posedge clk);
    #2;
    check_reset_state("reset_init");
    @(negedge clk);
    rst = 0;
    ms = '0;
    // Reset mid-run with a valid instruction in EX.
    step(alu_rr(5'd1, 5'd2, 5'd3, 32'd11, 32'd22), 1'b0, nf);
    drive_id('0, 1'b0);
    #2;
    rst = 1;
    #1;
    check_reset_state("reset_midrun");
    ms = '0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_add();
    fwd_t nf = '0;
    step(alu_rr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7), 1'b0, nf);
    checks++;
    if (alu_in1 !== 32'd5 || alu_in2 !== 32'd7 || alu_op !== 4'd0 || ex_rd !== 5'd3) begin
      errors++;
      $display("FAIL add: got in1=%0d in2=%0d op=%0d rd=%0d expected 5 7 0 3", alu_in1, alu_in2, alu_op, ex_rd);
    end
  endtask

  task automatic test_fwd_priority();
    fwd_t f;
    f = '{ew:1, erd:5'd1, eres:32'h10, ww:1, wrd:5'd1, wdata:32'h20};
    step(alu_rr(5'd1, 5'd2, 5'd5, 32'h99, 32'h3), 1'b0, f);
    checks++;
    if (alu_in1 !== 32'h10) begin
      errors++;
      $display("FAIL fwd_exmem_wins: got %h expected 00000010", alu_in1);
    end
    f = '{ew:1, erd:5'd0, eres:32'h10, ww:1, wrd:5'd0, wdata:32'h20};
    step(alu_rr(5'd1, 5'd2, 5'd5, 32'h99, 32'h3), 1'b0, f);
    checks++;
    if (alu_in1 !== 32'h99) begin
      errors++;
      $display("FAIL fwd_r0_never: got %h expected 00000099", alu_in1);
    end
    f = '{ew:0, erd:5'd1, eres:32'h10, ww:1, wrd:5'd2, wdata:32'h20};
    step(alu_rr(5'd1, 5'd2, 5'd5, 32'h99, 32'h3), 1'b0, f);
    checks++;
    if (alu_in1 !== 32'h99 || alu_in2 !== 32'h20) begin
      errors++;
      $display("FAIL fwd_memwb: got in1=%h in2=%h expected 00000099 00000020", alu_in1, alu_in2);
    end
  endtask

  task automatic test_load_use();
    fwd_t nf = '0;
    fwd_t wb = '{ew:0, erd:5'd0, eres:32'h0, ww:1, wrd:5'd4, wdata:32'hAB};
    instr_t dep = alu_rr(5'd4, 5'd2, 5'd6, 32'h1, 32'h2);
    step(load(5'd4), 1'b0, nf);
    step(dep, 1'b0, nf);          // stall cycle: bubble enters EX
    checks++;
    if (ex_valid !== 1'b0 || id_stall !== 1'b0) begin
      errors++;
      $display("FAIL load_use_bubble: got v=%b stall=%b expected 0 0", ex_valid, id_stall);
    end
    step(dep, 1'b0, wb);          // re-issued, forwards from MEM/WB
    checks++;
    if (alu_in1 !== 32'hAB || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL load_use_fwd: got in1=%h v=%b expected 000000ab 1", alu_in1, ex_valid);
    end
  endtask

  task automatic test_hazard_flush();
    fwd_t nf = '0;
    step(load(5'd4), 1'b0, nf);
    step(alu_rr(5'd2, 5'd4, 5'd6, 32'h1, 32'h2), 1'b1, nf);
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL hazard_flush: got v=%b rw=%b expected 0 0", ex_valid, ex_reg_write);
    end
  endtask

  task automatic test_reset_mid_stall();
    fwd_t nf = '0;
    step(load(5'd7), 1'b0, nf);
    @(negedge clk);
    drive_id(alu_rr(5'd7, 5'd1, 5'd8, 32'h1, 32'h2), 1'b0);
    #1;
    checks++;
    if (id_stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_before_rst: got %b expected 1", id_stall);
    end
    rst = 1;
    #1;
    check_reset_state("rst_mid_stall");
    ms = '0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_store();
    instr_t s = '0;
    fwd_t f = '{ew:1, erd:5'd6, eres:32'h55, ww:0, wrd:5'd0, wdata:32'h0};
    s.valid = 1; s.pc = 32'h300; s.rs = 5'd2; s.rt = 5'd6; s.rd = 5'd0;
    s.rs_data = 32'h1000; s.rt_data = 32'h77; s.imm = 32'd8; s.alu_src = 1; s.mw = 1;
    step(s, 1'b0, f);
    checks++;
    if (alu_in2 !== 32'd8 || ex_store_data !== 32'h55 || ex_mem_write !== 1'b1) begin
      errors++;
      $display("FAIL store: got in2=%h sd=%h mw=%b expected 00000008 00000055 1",
               alu_in2, ex_store_data, ex_mem_write);
    end
  endtask

  task automatic test_invalid();
    fwd_t nf = '0;
    instr_t i = load(5'd3);
    i.valid = 0; i.mw = 1;
    step(i, 1'b0, nf);
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0) begin
      errors++;
      $display("FAIL invalid_ctrl: got v=%b rw=%b mr=%b mw=%b expected 0 0 0 0",
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      instr_t i;
      fwd_t f;
      i.valid = ($urandom_range(0, 7) != 0);
      i.pc = $urandom; i.rs = 5'($urandom_range(0, 3)); i.rt = 5'($urandom_range(0, 3));
      i.rd = 5'($urandom_range(0, 3)); i.rs_data = $urandom; i.rt_data = $urandom;
      i.imm = $urandom; i.alu_src = 1'($urandom_range(0, 1)); i.alu_op = 4'($urandom_range(0, 9));
      i.shamt = 5'($urandom); i.rw = 1'($urandom_range(0, 1)); i.mr = 1'($urandom_range(0, 1));
      i.mw = 1'($urandom_range(0, 1)); i.m2r = i.mr;
      f.ew = 1'($urandom_range(0, 1)); f.erd = 5'($urandom_range(0, 3)); f.eres = $urandom;
      f.ww = 1'($urandom_range(0, 1)); f.wrd = 5'($urandom_range(0, 3)); f.wdata = $urandom;
      step(i, ($urandom_range(0, 9) == 0), f);
    end
  endtask

  initial begin
    ms = '0;
    test_reset();
    test_add();
    test_fwd_priority();
    test_load_use();
    test_hazard_flush();
    test_store();
    test_invalid();
    test_reset_mid_stall();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
